// File: rtl/apt_rmw_writer_pkg.sv
// Shared types and default widths for the APT read-modify-write writer.
// The op_del entry field exists only when APT_DELETE_EN is defined.
package apt_pkg;

  localparam int APT_W      = 16;
  localparam int APT_RID_W  = 6;
  localparam int APT_FIFO_D = 4;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WT,
    WR
  } apt_state_e;

  typedef struct packed {
    logic [APT_W-1:0]     apta;
    logic [APT_RID_W-1:0] rule_id;
    logic                 last;
`ifdef APT_DELETE_EN
    logic                 op_del;
`endif
  } apt_entry_t;

  // Packed width of one buffered entry for arbitrary address / rule-id widths.
  function automatic int apt_entry_bits(input int aw, input int rw);
`ifdef APT_DELETE_EN
    return aw + rw + 2;
`else
    return aw + rw + 1;
`endif
  endfunction

endpackage

// File: rtl/apt_rmw_writer_if.sv
// APT address stream from the address generator into the RMW writer.
// The master drives entries, the slave returns apta_ready.
interface apt_rmw_writer_if #(
  parameter int W     = 16,
  parameter int RID_W = 6
);

  logic             apta_valid;
  logic             apta_ready;
  logic [W-1:0]     apta;
  logic [RID_W-1:0] rule_id;
  logic             last;
  logic             op_del;

  modport master (
    output apta_valid,
    output apta,
    output rule_id,
    output last,
    output op_del,
    input  apta_ready
  );

  modport slave (
    input  apta_valid,
    input  apta,
    input  rule_id,
    input  last,
    input  op_del,
    output apta_ready
  );

endinterface

// File: rtl/apt_rmw_writer_fifo.sv
// Synchronous first-word-fall-through FIFO buffering APT entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module apt_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_wdata,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_push;
  logic          w_pop;

  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // No push-through: a full FIFO refuses even when popped in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/apt_rmw_writer.sv
// Buffers APT row addresses and sets (or, with APT_DELETE_EN, clears) the
// rule's bit in each addressed SRAM row via a serialized read-modify-write.
module apt_rmw_writer
  import apt_pkg::*;
#(
  parameter int w      = APT_W,
  parameter int RID_W  = APT_RID_W,
  parameter int FIFO_D = APT_FIFO_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  apt_rmw_writer_if.slave     s_apt,
  output logic                mem_ren,
  output logic                mem_wen,
  output logic [w-1:0]        mem_addr,
  output logic [2**RID_W-1:0] mem_wdata,
  input  logic [2**RID_W-1:0] mem_rdata,
  output logic                busy,
  output logic                done
);

  localparam int N       = 2**RID_W;
  localparam int ENTRY_W = apt_entry_bits(w, RID_W);
  localparam logic [N-1:0] BIT0 = N'(1);

  typedef struct packed {
    logic [w-1:0]     apta;
    logic [RID_W-1:0] rule_id;
    logic             last;
`ifdef APT_DELETE_EN
    logic             op_del;
`endif
  } entry_t;

  apt_state_e               r_state;
  entry_t                   r_hold;
  logic                     r_mem_ren;
  logic                     r_mem_wen;
  logic [w-1:0]             r_mem_addr;
  logic [N-1:0]             r_mem_wdata;
  logic                     r_done;

  entry_t                   w_in;
  entry_t                   w_head;
  logic [ENTRY_W-1:0]       w_fifo_rdata;
  logic                     w_full;
  logic                     w_empty;
  logic [$clog2(FIFO_D):0]  w_count;
  logic                     w_push;
  logic                     w_pop;
  logic [N-1:0]             w_mask;
  logic [N-1:0]             w_new_row;

  always_comb begin
    w_in         = '0;
    w_in.apta    = s_apt.apta;
    w_in.rule_id = s_apt.rule_id;
    w_in.last    = s_apt.last;
`ifdef APT_DELETE_EN
    w_in.op_del  = s_apt.op_del;
`endif
  end

  assign w_push = s_apt.apta_valid && !w_full;
  assign w_pop  = (r_state == IDLE) && en && !w_empty;
  assign w_head = entry_t'(w_fifo_rdata);

  apt_fifo #(
    .DW    (ENTRY_W),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_in),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_mask = BIT0 << r_hold.rule_id;
`ifdef APT_DELETE_EN
  assign w_new_row = r_hold.op_del ? (mem_rdata & ~w_mask) : (mem_rdata | w_mask);
`else
  logic w_unused_del;
  assign w_new_row    = mem_rdata | w_mask;
  assign w_unused_del = s_apt.op_del;
`endif

  // Strobes, address and data are registered; they default to zero each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_mem_ren   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
    end else begin
      r_mem_ren   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_hold     <= w_head;
            r_state    <= RD;
            r_mem_ren  <= 1'b1;
            r_mem_addr <= w_head.apta;
          end
        end
        RD: begin
          r_state <= WT;
        end
        WT: begin
          // Read data is valid now; merge it straight into the write beat.
          r_state     <= WR;
          r_mem_wen   <= 1'b1;
          r_mem_addr  <= r_hold.apta;
          r_mem_wdata <= w_new_row;
        end
        WR: begin
          r_state <= IDLE;
          r_done  <= r_hold.last;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_ren          = r_mem_ren;
  assign mem_wen          = r_mem_wen;
  assign mem_addr         = r_mem_addr;
  assign mem_wdata        = r_mem_wdata;
  assign done             = r_done;
  assign busy             = (r_state != IDLE) || (w_count != '0);
  assign s_apt.apta_ready = !w_full;

endmodule

// File: tb/tb_apt_rmw_writer.sv
// Self-checking bench for apt_rmw_writer: directed cases plus randomized
// stimulus checked every cycle against a queue-and-shadow-memory model.
module tb_apt_rmw_writer;

  localparam int W      = 16;
  localparam int RID_W  = 6;
  localparam int N      = 64;
  localparam int FIFO_D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         mem_ren;
  logic         mem_wen;
  logic [W-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata = '0;
  logic         busy;
  logic         done;

  apt_rmw_writer_if #(.W(W), .RID_W(RID_W)) apt_if ();

  apt_rmw_writer #(.w(W), .RID_W(RID_W), .FIFO_D(FIFO_D)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .s_apt     (apt_if),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    int           rid;
    bit           last;
    bit           del;
  } ent_t;

  logic [N-1:0] sram   [0:65535] = '{default: '0};
  logic [N-1:0] shadow [0:65535] = '{default: '0};
  ent_t         q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wen_count = 0, done_count = 0;
  int last_push_cyc = 0, last_ren_cyc = 0, last_wen_cyc = 0, last_done_cyc = 0;
  logic [W-1:0] last_waddr = '0;
  logic [N-1:0] last_wdata = '0;
  bit pend_done = 1'b0;
  bit rst_prev  = 1'b0;

  logic         pl_valid = 1'b0;
  logic [W-1:0] pl_addr  = '0;
  logic [N-1:0] pl_data  = '0;

  function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  // SRAM with one-cycle read latency; pl_* is the bench's preload port.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= sram[mem_addr];
    if (mem_wen) sram[mem_addr] <= mem_wdata;
    if (pl_valid) sram[pl_addr] <= pl_data;
  end

  // Per-cycle compare: queue head is the oldest entry not yet written back.
  always @(negedge clk) begin
    ent_t e;
    logic [N-1:0] exp_w;
    bit exp_done;
    cyc++;
    if (pl_valid) shadow[pl_addr] = pl_data;
    if (rst) begin
      if (rst_prev) begin
        check("rst_ren", mem_ren, 0);
        check("rst_wen", mem_wen, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", apt_if.apta_ready, 1);
        check("rst_addr", mem_addr, 0);
      end
      q.delete();
      pend_done = 1'b0;
    end else begin
      exp_done  = pend_done;
      pend_done = 1'b0;
      check("done", done, exp_done);
      if (done) begin
        done_count++;
        last_done_cyc = cyc;
      end
      check("busy", busy, q.size() != 0);
      if (q.size() < FIFO_D) check("ready_free", apt_if.apta_ready, 1);
      else if (q.size() > FIFO_D) check("ready_full", apt_if.apta_ready, 0);
      check("ren_wen_excl", mem_ren && mem_wen, 0);
      if (!mem_ren && !mem_wen) begin
        check("idle_addr", mem_addr, 0);
        check("idle_wdata", mem_wdata, 0);
      end
      if (mem_ren) begin
        last_ren_cyc = cyc;
        check("ren_has_entry", q.size() != 0, 1);
        if (q.size() != 0) check("ren_addr", mem_addr, q[0].a);
        check("ren_wdata", mem_wdata, 0);
      end
      if (mem_wen) begin
        wen_count++;
        last_wen_cyc = cyc;
        last_waddr = mem_addr;
        last_wdata = mem_wdata;
        check("wen_has_entry", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          exp_w = shadow[e.a] | (64'd1 << e.rid);
`ifdef APT_DELETE_EN
          if (e.del) exp_w = shadow[e.a] & ~(64'd1 << e.rid);
`endif
          shadow[e.a] = exp_w;
          check("wen_addr", mem_addr, e.a);
          check("wen_wdata", mem_wdata, exp_w);
          pend_done = e.last;
          $display("write addr=%h rule=%0d last=%0d data=%h", mem_addr, e.rid, e.last, mem_wdata);
        end
      end
      if (apt_if.apta_valid && apt_if.apta_ready) begin
        e.a    = apt_if.apta;
        e.rid  = int'(apt_if.rule_id);
        e.last = apt_if.last;
        e.del  = apt_if.op_del;
        q.push_back(e);
        last_push_cyc = cyc;
      end
    end
    rst_prev = rst;
  end

  task automatic push(input logic [W-1:0] a, input int rid, input bit last, input bit del);
    int g = 0;
    @(posedge clk); #1;
    apt_if.apta_valid = 1'b1;
    apt_if.apta       = a;
    apt_if.rule_id    = rid[RID_W-1:0];
    apt_if.last       = last;
    apt_if.op_del     = del;
    while (!apt_if.apta_ready && g < 100) begin
      @(posedge clk); #1;
      en = 1'b1;
      g++;
    end
    if (!apt_if.apta_ready) check("push_timeout", 0, 1);
  endtask

  task automatic drop();
    @(posedge clk); #1;
    apt_if.apta_valid = 1'b0;
  endtask

  task automatic preload(input logic [W-1:0] a, input logic [N-1:0] d);
    @(posedge clk); #1;
    pl_valid = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    do begin
      @(posedge clk); #1;
      g++;
    end while ((busy || q.size() != 0) && g < 300);
    if (g >= 300) check("idle_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int w0, d0, k0;
    logic [N-1:0] exp6;
    apt_if.apta_valid = 1'b0;
    apt_if.apta = '0;
    apt_if.rule_id = '0;
    apt_if.last = 1'b0;
    apt_if.op_del = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_ready", apt_if.apta_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_ren", mem_ren, 0);
    check("reset_wen", mem_wen, 0);
    check("reset_done", done, 0);
    en = 1'b1;

    // 1: single entry, latency pinned
    push(16'h0005, 3, 1'b1, 1'b0);
    drop();
    wait_idle();
    check("t1_ren_lat", last_ren_cyc - last_push_cyc, 2);
    check("t1_wen_lat", last_wen_cyc - last_push_cyc, 4);
    check("t1_done_lat", last_done_cyc - last_push_cyc, 5);
    check("t1_addr", last_waddr, 16'h0005);
    check("t1_wdata", last_wdata, 64'h8);

    // 2: read-modify-write keeps existing bits
    preload(16'h0005, 64'h8);
    push(16'h0005, 0, 1'b1, 1'b0);
    drop();
    wait_idle();
    check("t2_wdata", last_wdata, 64'h9);

    // 3: fill with en low, then drain four in order
    @(posedge clk); #1 en = 1'b0;
    for (int i = 0; i < 4; i++) push(16'h0010 + 16'(i), i, i == 3, 1'b0);
    @(posedge clk); #1;
    apt_if.apta = 16'h0014;
    apt_if.last = 1'b0;
    check("t3_full_ready", apt_if.apta_ready, 0);
    w0 = wen_count;
    repeat (2) @(posedge clk);
    #1;
    check("t3_hold_no_wen", wen_count - w0, 0);
    check("t3_still_full", apt_if.apta_ready, 0);
    apt_if.apta_valid = 1'b0;
    en = 1'b1;
    k0 = cyc;
    d0 = done_count;
    wait_idle();
    check("t3_wen_count", wen_count - w0, 4);
    check("t3_done_count", done_count - d0, 1);
    check("t3_last_wen", last_wen_cyc - k0, 16);
    check("t3_done_time", last_done_cyc - k0, 17);

    // 4: back-to-back writes to the same row
    push(16'h00FF, 1, 1'b0, 1'b0);
    push(16'h00FF, 2, 1'b1, 1'b0);
    drop();
    wait_idle();
    check("t4_row", sram[16'h00FF], 64'h6);

    // 5: reset while waiting for read data
    preload(16'h0020, 64'h1);
    push(16'h0020, 4, 1'b1, 1'b0);
    drop();
    w0 = wen_count;
    k0 = last_ren_cyc;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_ren_seen", last_ren_cyc != k0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_no_wen", mem_wen, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", apt_if.apta_ready, 1);
    repeat (4) @(posedge clk);
    #1;
    check("t5_wen_count", wen_count - w0, 0);
    check("t5_row", sram[16'h0020], 64'h1);

    // 6: delete operation
    preload(16'h0030, 64'hF);
    push(16'h0030, 2, 1'b1, 1'b1);
    drop();
    wait_idle();
`ifdef APT_DELETE_EN
    exp6 = 64'hB;
`else
    exp6 = 64'hF;
`endif
    check("t6_wdata", last_wdata, exp6);
    check("t6_addr", last_waddr, 16'h0030);

    // Randomized traffic over a few rows with en toggling
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        drop();
        en = ($urandom_range(0, 2) != 0);
      end
      push(16'h0040 + 16'($urandom_range(0, 7)), $urandom_range(0, 63),
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end
    drop();
    en = 1'b1;
    wait_idle();
    for (int a = 16'h40; a < 16'h48; a++) check("rand_row", sram[a], shadow[a]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
